// File: rtl/music_beat_player.sv
`default_nettype none
// ----------------------------------------------------------------------------
// music_beat_player: beat-indexed tone playback with iterative half-period
// divider and 50% duty square-wave output.                     Rev 1.0
// ----------------------------------------------------------------------------
module music_beat_player #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BEAT_HZ    = 8,
  parameter int unsigned LAST_BEAT  = 63,
  parameter int unsigned SILENCE_HZ = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [31:0] tone,
  output logic [7:0]  ibeatNum,
  output logic        audio_out,
  output logic        playing,
  output logic        done
);

  localparam logic [31:0] TICK     = 32'(CLK_HZ / BEAT_HZ);
  localparam logic [7:0]  LAST     = 8'(LAST_BEAT);
  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
  localparam logic [31:0] SILENCE  = 32'(SILENCE_HZ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] tick_q, tick_d;
  logic        samp_q, samp_d;
  logic [31:0] tone_s_q, tone_s_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic [5:0]  iter_q, iter_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] hp_q, hp_d;
  logic [31:0] phase_q, phase_d;
  logic        audio_q, audio_d;

  logic        rest_w;
  logic [32:0] rem_shift_w;
  logic [31:0] rem_diff_w;
  logic        ge_w;
  logic [31:0] quo_next_w;

  // Sequencer: state, beat index and tick counter
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tick_d  = tick_q;
    samp_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        beat_d = 8'd0;
        tick_d = 32'd0;
        if (start && !stop) begin
          state_d = S_PLAY;
          samp_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          beat_d  = 8'd0;
          tick_d  = 32'd0;
        end else if (start) begin
          beat_d = 8'd0;
          tick_d = 32'd0;
          samp_d = 1'b1;
        end else if (tick_q == TICK - 32'd1) begin
          tick_d = 32'd0;
          if (beat_q < LAST) begin
            beat_d = beat_q + 8'd1;
            samp_d = 1'b1;
          end else if (loop_en) begin
            beat_d = 8'd0;
            samp_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        beat_d  = 8'd0;
        tick_d  = 32'd0;
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 8'd0;
        tick_d  = 32'd0;
      end
    endcase
  end

  // Tone capture and restoring divider: quotient = CLK_HZ / (2*tone)
  assign rest_w      = (tone_s_q == 32'd0) || (tone_s_q >= SILENCE);
  assign rem_shift_w = {rem_q, quo_q[31]};
  assign ge_w        = rem_shift_w >= {1'b0, dvs_q};
  assign rem_diff_w  = rem_shift_w[31:0] - dvs_q;
  assign quo_next_w  = {quo_q[30:0], ge_w};

  always_comb begin
    tone_s_d = tone_s_q;
    load_d   = 1'b0;
    busy_d   = busy_q;
    iter_d   = iter_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    hp_d     = hp_q;
    if (samp_q && state_q == S_PLAY) begin
      tone_s_d = tone;
      load_d   = 1'b1;
    end
    // A fresh load takes priority, so a newer tone aborts an in-flight divide
    if (load_q) begin
      if (rest_w) begin
        busy_d = 1'b0;
        hp_d   = 32'd0;
      end else begin
        busy_d = 1'b1;
        iter_d = 6'd32;
        quo_d  = DIVIDEND;
        rem_d  = 32'd0;
        dvs_d  = {tone_s_q[30:0], 1'b0};
      end
    end else if (busy_q) begin
      quo_d  = quo_next_w;
      rem_d  = ge_w ? rem_diff_w : rem_shift_w[31:0];
      iter_d = iter_q - 6'd1;
      if (iter_q == 6'd1) begin
        busy_d = 1'b0;
        hp_d   = (quo_next_w == 32'd0) ? 32'd1 : quo_next_w;
      end
    end
  end

  // Square wave; phase restarts on entry to PLAY and whenever the period changes
  always_comb begin
    phase_d = phase_q;
    audio_d = audio_q;
    if (state_d != S_PLAY || hp_d == 32'd0) begin
      phase_d = 32'd0;
      audio_d = 1'b0;
    end else if (state_q != S_PLAY || hp_d != hp_q) begin
      phase_d = 32'd0;
    end else if (phase_q == hp_q - 32'd1) begin
      phase_d = 32'd0;
      audio_d = ~audio_q;
    end else begin
      phase_d = phase_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= 8'd0;
      tick_q   <= 32'd0;
      samp_q   <= 1'b0;
      tone_s_q <= 32'd0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      iter_q   <= 6'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
      hp_q     <= 32'd0;
      phase_q  <= 32'd0;
      audio_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tick_q   <= tick_d;
      samp_q   <= samp_d;
      tone_s_q <= tone_s_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      iter_q   <= iter_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      hp_q     <= hp_d;
      phase_q  <= phase_d;
      audio_q  <= audio_d;
    end
  end

  assign ibeatNum  = beat_q;
  assign audio_out = audio_q;
  assign playing   = (state_q == S_PLAY);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_music_beat_player.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_music_beat_player: table vectors, timing-model random playback, corners.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_music_beat_player;

  localparam int CLK_HZ  = 100_000;
  localparam int BEAT_HZ = 100;
  localparam int LAST    = 23;
  localparam int SIL     = 20000;
  localparam int TICK    = CLK_HZ / BEAT_HZ;
  localparam int NPLAY   = (LAST + 1) * TICK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [31:0] tone;
  logic [7:0]  ibeatNum;
  logic        audio_out;
  logic        playing;
  logic        done;

  logic [31:0] tone_tab [0:255];

  int n_cmp = 0;
  int n_err = 0;
  int m_hp  = 0;
  bit m_audio = 1'b0;

  typedef struct {
    int unsigned tone;
    int          hp;
  } vec_t;
  vec_t vecs [8];

  music_beat_player #(
    .CLK_HZ    (CLK_HZ),
    .BEAT_HZ   (BEAT_HZ),
    .LAST_BEAT (LAST),
    .SILENCE_HZ(SIL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .tone     (tone),
    .ibeatNum (ibeatNum),
    .audio_out(audio_out),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;
  assign tone = tone_tab[ibeatNum];

  function automatic int hp_of(input int unsigned t);
    int q;
    if (t == 0 || t >= SIL) return 0;
    q = CLK_HZ / (2 * t);
    return (q == 0) ? 1 : q;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_hp = 0; m_audio = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic fill_table(input int unsigned t);
    for (int b = 0; b < 256; b++) tone_tab[b] = t;
  endtask

  task automatic fill_random();
    int r;
    for (int b = 0; b < 256; b++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      tone_tab[b] = 0;
      else if (r == 1) tone_tab[b] = $urandom_range(SIL, 60000);
      else             tone_tab[b] = $urandom_range(60, 12000);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_playing"}, playing, 0);
    chk({nm, "_beat"}, ibeatNum, 0);
    chk({nm, "_audio"}, audio_out, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  // Timing model: beat b spans edges b*TICK.., tone sampled one edge later;
  // rests commit at +2, real tones at +34; waveform toggles every hp edges.
  task automatic play_and_check(input int ncyc, input bit lp, input string nm);
    int st, b, v, nh, seg, ndone;
    bit lvl0, ea;
    seg = 0; ndone = 0; lvl0 = 1'b0;
    loop_en = lp;
    pulse_start();
    for (int n = 0; n < ncyc; n++) begin
      if (!lp && n >= NPLAY) st = (n == NPLAY) ? 2 : 0;
      else                   st = 1;
      b  = (n / TICK) % (LAST + 1);
      nh = m_hp;
      if (st == 1) begin
        v = hp_of(tone_tab[b]);
        if ((v == 0 && n % TICK == 2) || (v != 0 && n % TICK == 34)) nh = v;
      end
      if (st != 1 || nh == 0) ea = 1'b0;
      else if (n == 0 || nh != m_hp) begin
        seg = n; lvl0 = m_audio; ea = lvl0;
      end else ea = lvl0 ^ 1'(((n - seg) / nh) & 1);
      m_hp = nh; m_audio = ea;
      chk({nm, "_playing"}, playing, (st == 1) ? 1 : 0);
      chk({nm, "_done"}, done, (st == 2) ? 1 : 0);
      chk({nm, "_audio"}, audio_out, ea);
      if (st != 2) chk({nm, "_beat"}, ibeatNum, (st == 1) ? b : 0);
      if (done) ndone++;
      @(negedge clk);
    end
    chk({nm, "_done_count"}, ndone, lp ? 0 : 1);
  endtask

  initial begin
    int t1, t2, lim;
    vecs[0] = '{523, 95};
    vecs[1] = '{784, 63};
    vecs[2] = '{440, 113};
    vecs[3] = '{10000, 5};
    vecs[4] = '{19999, 2};
    vecs[5] = '{20000, 0};
    vecs[6] = '{0, 0};
    vecs[7] = '{25000, 0};
    fill_table(0);

    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    // Divider / rest vectors: first rise at 34+hp after start, then period hp
    for (int i = 0; i < 8; i++) begin
      do_reset();
      fill_table(vecs[i].tone);
      loop_en = 1'b1;
      pulse_start();
      t1 = -1; t2 = -1;
      lim = (vecs[i].hp != 0) ? 34 + 3 * vecs[i].hp + 10 : 400;
      for (int n = 0; n < lim; n++) begin
        if (t1 < 0 && audio_out) t1 = n;
        else if (t1 >= 0 && t2 < 0 && !audio_out) t2 = n;
        @(negedge clk);
      end
      chk($sformatf("vec%0d_first_rise", i), t1, (vecs[i].hp != 0) ? 34 + vecs[i].hp : -1);
      if (vecs[i].hp != 0)
        chk($sformatf("vec%0d_half_period", i), t2 - t1, vecs[i].hp);
      pulse_stop();
    end

    // Rest on beat 0, 784 Hz from beat 1
    do_reset();
    fill_table(784);
    tone_tab[0] = 20000;
    play_and_check(1500, 1'b1, "stepped");
    pulse_stop();
    chk_idle("stepped_stop");

    // Looped random tune across the wrap
    do_reset();
    fill_random();
    play_and_check(NPLAY + 2500, 1'b1, "loop");
    pulse_stop();
    chk_idle("loop_stop");

    // One-shot random tune ending in a single done pulse
    fill_random();
    play_and_check(NPLAY + 5, 1'b0, "oneshot");

    // Stop mid-divide at beat 10
    fill_table(523);
    loop_en = 1'b1;
    pulse_start();
    wait_cyc(10 * TICK + 10);
    chk("stop_pre_beat", ibeatNum, 10);
    pulse_stop();
    chk_idle("stop_mid");

    // start+stop together, from IDLE and from PLAY
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    chk_idle("both_idle");
    pulse_start();
    wait_cyc(50);
    chk("both_pre_playing", playing, 1);
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    chk_idle("both_play");

    // Restart while playing
    pulse_start();
    wait_cyc(2500);
    chk("restart_pre_beat", ibeatNum, 2);
    pulse_start();
    chk("restart_beat", ibeatNum, 0);
    chk("restart_playing", playing, 1);
    wait_cyc(999);
    chk("restart_beat_hold", ibeatNum, 0);
    wait_cyc(1);
    chk("restart_beat_next", ibeatNum, 1);
    pulse_stop();

    // One-cycle reset mid-tone at beat 5, then fresh playback
    pulse_start();
    wait_cyc(5 * TICK + 300);
    chk("rst_pre_beat", ibeatNum, 5);
    chk("rst_pre_playing", playing, 1);
    do_reset();
    chk_idle("rst_mid");
    play_and_check(1500, 1'b1, "after_rst");
    pulse_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
